// File: rtl/jpeg_pkg.sv
// Shared JPEG constants: coefficient widths, block size and the standard
// luminance quantization table (raster order), used by quantizer and dequantizer.
package jpeg_pkg;

  localparam int QW         = 8;
  localparam int DW         = 12;
  localparam int BLOCK_SIZE = 64;
  localparam int IDX_W      = $clog2(BLOCK_SIZE);

  localparam logic [7:0] LUMA_QTABLE [BLOCK_SIZE] = '{
    8'd16,  8'd11,  8'd10,  8'd16,  8'd24,  8'd40,  8'd51,  8'd61,
    8'd12,  8'd12,  8'd14,  8'd19,  8'd26,  8'd58,  8'd60,  8'd55,
    8'd14,  8'd13,  8'd16,  8'd24,  8'd40,  8'd57,  8'd69,  8'd56,
    8'd14,  8'd17,  8'd22,  8'd29,  8'd51,  8'd87,  8'd80,  8'd62,
    8'd18,  8'd22,  8'd37,  8'd56,  8'd68,  8'd109, 8'd103, 8'd77,
    8'd24,  8'd35,  8'd55,  8'd64,  8'd81,  8'd104, 8'd113, 8'd92,
    8'd49,  8'd64,  8'd78,  8'd87,  8'd103, 8'd121, 8'd120, 8'd101,
    8'd72,  8'd92,  8'd95,  8'd98,  8'd112, 8'd100, 8'd103, 8'd99
  };

endpackage

// File: rtl/jpeg_qtable_rom.sv
// Combinational lookup of the luminance quantization step for a raster index.
module jpeg_qtable_rom
  import jpeg_pkg::*;
(
  input  logic [5:0] addr,
  output logic [7:0] q_val
);

  assign q_val = LUMA_QTABLE[addr];

endmodule

// File: rtl/jpeg_dequantizer.sv
// Two-stage dequantizer: table lookup, then exact multiply with saturation to a
// signed DW-bit DCT coefficient; valid/ready on both sides with a tracked block index.
module jpeg_dequantizer #(
  parameter int QW = jpeg_pkg::QW,
  parameter int DW = jpeg_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sop,
  input  logic [QW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [5:0]    out_addr,
  output logic          out_last,
  output logic          out_sat,
  output logic          err_align
);

  import jpeg_pkg::*;

  localparam int PW = QW + 8;
  localparam logic signed [PW-1:0] SAT_MAX = PW'(2 ** (DW - 1) - 1);
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [5:0]           LAST_IDX = 6'(BLOCK_SIZE - 1);

  logic [5:0]    idx_reg;
  logic          block_done_reg;
  logic          err_align_reg;

  logic          s1_valid_reg;
  logic [QW-1:0] s1_data_reg;
  logic [5:0]    s1_addr_reg;
  logic [7:0]    s1_q_reg;

  logic          s2_valid_reg;
  logic [DW-1:0] out_data_reg;
  logic [5:0]    out_addr_reg;
  logic          out_last_reg;
  logic          out_sat_reg;

  logic          accept;
  logic          s1_load;
  logic          s2_load;
  logic [5:0]    beat_idx;
  logic          align_bad;
  logic [7:0]    q_val;

  logic signed [PW-1:0] data_ext;
  logic signed [PW-1:0] q_ext;
  logic signed [PW-1:0] product;
  logic [DW-1:0]        sat_data;
  logic                 sat_flag;

  // Stage 1 may refill in the same cycle stage 2 drains, so there is no
  // bubble when a stall releases.
  assign s2_load  = !s2_valid_reg || out_ready;
  assign s1_load  = !s1_valid_reg || s2_load;
  assign in_ready = s1_load;
  assign accept   = in_valid && in_ready;

  assign beat_idx  = in_sop ? 6'd0 : idx_reg;
  // Unsolicited wrap to index 0 is only an error once a full block has been seen.
  assign align_bad = in_sop ? (idx_reg != 6'd0)
                            : ((idx_reg == 6'd0) && block_done_reg);

  jpeg_qtable_rom u_qtable_rom (
    .addr  (beat_idx),
    .q_val (q_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg        <= '0;
      block_done_reg <= 1'b0;
      err_align_reg  <= 1'b0;
    end else if (accept) begin
      idx_reg <= beat_idx + 6'd1;
      if (beat_idx == LAST_IDX) begin
        block_done_reg <= 1'b1;
      end
      if (align_bad) begin
        err_align_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_addr_reg  <= '0;
      s1_q_reg     <= '0;
    end else if (s1_load) begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_data_reg <= in_data;
        s1_addr_reg <= beat_idx;
        s1_q_reg    <= q_val;
      end
    end
  end

  // The product of a signed QW-bit value and an unsigned 8-bit step always
  // fits in QW+8 signed bits, so no wider intermediate is needed.
  always_comb begin
    data_ext = PW'($signed(s1_data_reg));
    q_ext    = PW'(s1_q_reg);
    product  = data_ext * q_ext;
    sat_data = product[DW-1:0];
    sat_flag = 1'b0;
    if (product > SAT_MAX) begin
      sat_data = SAT_MAX[DW-1:0];
      sat_flag = 1'b1;
    end else if (product < SAT_MIN) begin
      sat_data = SAT_MIN[DW-1:0];
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      out_data_reg <= '0;
      out_addr_reg <= '0;
      out_last_reg <= 1'b0;
      out_sat_reg  <= 1'b0;
    end else if (s2_load) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_data_reg <= sat_data;
        out_addr_reg <= s1_addr_reg;
        out_last_reg <= (s1_addr_reg == LAST_IDX);
        out_sat_reg  <= sat_flag;
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_data  = out_data_reg;
  assign out_addr  = out_addr_reg;
  assign out_last  = out_last_reg;
  assign out_sat   = out_sat_reg;
  assign err_align = err_align_reg;

endmodule

// File: tb/tb_jpeg_dequantizer.sv
// Self-checking bench for jpeg_dequantizer: queue-based reference model with a
// per-cycle compare process, plus directed literal expectations.
module tb_jpeg_dequantizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sop;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [5:0]  out_addr;
  logic        out_last;
  logic        out_sat;
  logic        err_align;

  jpeg_dequantizer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sop    (in_sop),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .out_sat   (out_sat),
    .err_align (err_align)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int addr;
    int sat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   rdy_mode = 0;

  int qtab [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,
    12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,
    14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77,
    24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103, 99
  };

  int m_idx;
  bit m_done;
  bit m_err;
  int cap_data [64];
  int cap_sat  [64];
  int acc_cyc0;
  int out_cyc0;

  bit          prev_stall;
  logic [11:0] prev_data;
  logic [5:0]  prev_addr;
  logic        prev_last;
  logic        prev_sat;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic int model_val(input int idx, input int d);
    int p;
    p = qtab[idx] * d;
    if (p > 2047) return 2047;
    if (p < -2048) return -2048;
    return p;
  endfunction

  function automatic int model_sat(input int idx, input int d);
    int p;
    p = qtab[idx] * d;
    return (p > 2047 || p < -2048) ? 1 : 0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: checks everything observable once per cycle, then
  // advances the model with whatever handshakes complete at the next edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_idx = 0;
      m_done = 0;
      m_err = 0;
      prev_stall = 0;
      acc_cyc0 = -1;
      out_cyc0 = -1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_err_align", int'(err_align), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_addr", int'(out_addr), 0);
    end else begin
      chk("err_align", int'(err_align), int'(m_err));
      chk("in_ready", int'(in_ready), (exp_q.size() < 2 || out_ready) ? 1 : 0);
      if (prev_stall) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_data", int'(out_data), int'(prev_data));
        chk("stall_addr", int'(out_addr), int'(prev_addr));
        chk("stall_last_sat", int'({out_last, out_sat}), int'({prev_last, prev_sat}));
      end
      if (out_valid) begin
        if (out_cyc0 < 0) out_cyc0 = cyc;
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else if (out_ready) begin
          exp_t e;
          e = exp_q.pop_front();
          $display("out addr=%0d data=%0d sat=%0d last=%0d", out_addr,
                   $signed(out_data), out_sat, out_last);
          chk("out_data", int'($signed(out_data)), e.data);
          chk("out_addr", int'(out_addr), e.addr);
          chk("out_last", int'(out_last), (e.addr == 63) ? 1 : 0);
          chk("out_sat", int'(out_sat), e.sat);
          cap_data[out_addr] = int'($signed(out_data));
          cap_sat[out_addr]  = int'(out_sat);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_addr  = out_addr;
      prev_last  = out_last;
      prev_sat   = out_sat;
      if (in_valid && in_ready) begin
        int   bi;
        int   d;
        exp_t e;
        d = int'($signed(in_data));
        if (acc_cyc0 < 0) acc_cyc0 = cyc;
        if (in_sop) begin
          if (m_idx != 0) m_err = 1;
          bi = 0;
        end else begin
          if (m_idx == 0 && m_done) m_err = 1;
          bi = m_idx;
        end
        m_idx = (bi + 1) % 64;
        if (bi == 63) m_done = 1;
        e.data = model_val(bi, d);
        e.addr = bi;
        e.sat  = model_sat(bi, d);
        exp_q.push_back(e);
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input bit sop, input int d);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_sop   = sop;
    in_data  = d[7:0];
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Unit data reproduces the table itself.
    rdy_mode = 0;
    for (int i = 0; i < 64; i++) send(i == 0, 1);
    drain();
    chk("latency", out_cyc0 - acc_cyc0, 2);
    chk("tab0", cap_data[0], 16);
    chk("tab1", cap_data[1], 11);
    chk("tab2", cap_data[2], 10);
    chk("tab37", cap_data[37], 109);
    chk("tab63", cap_data[63], 99);

    // Saturation corners.
    for (int i = 0; i < 64; i++) send(i == 0, (i < 2) ? -128 : ((i == 37) ? 20 : 0));
    drain();
    chk("sat37_data", cap_data[37], 2047);
    chk("sat37_flag", cap_sat[37], 1);
    chk("neg0_data", cap_data[0], -2048);
    chk("neg0_flag", cap_sat[0], 0);
    chk("neg1_data", cap_data[1], -1408);
    chk("neg1_flag", cap_sat[1], 0);
    for (int i = 0; i < 64; i++) send(i == 0, (i == 0) ? 5 : 0);
    drain();
    chk("five0_data", cap_data[0], 80);

    // Random data under random backpressure and input gaps.
    rdy_mode = 1;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 64; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        send(i == 0, int'($urandom_range(0, 255)));
      end
    end
    drain();
    rdy_mode = 0;

    // Early in_sop restarts the block and latches err_align.
    for (int i = 0; i < 10; i++) send(i == 0, 1);
    chk("align_clean", int'(err_align), 0);
    send(1, 3);
    chk("align_err", int'(err_align), 1);
    for (int i = 1; i < 64; i++) send(0, 2);
    drain();
    chk("align_addr0", cap_data[0], 48);
    for (int i = 0; i < 64; i++) send(i == 0, int'($urandom_range(0, 255)));
    drain();

    // Block following a completed one without in_sop wraps and flags.
    do_reset();
    for (int i = 0; i < 64; i++) send(i == 0, 1);
    chk("wrap_clean", int'(err_align), 0);
    send(0, 4);
    chk("wrap_err", int'(err_align), 1);
    for (int i = 1; i < 64; i++) send(0, 1);
    drain();
    chk("wrap_addr0", cap_data[0], 64);

    // Mid-block reset while the output is stalled.
    do_reset();
    for (int i = 0; i < 20; i++) send(i == 0, 1);
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_valid", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) send(i == 0, 2);
    drain();
    chk("post_rst_addr0", cap_data[0], 32);
    chk("post_rst_err", int'(err_align), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jpeg_dequantizer.md
# jpeg_dequantizer

Inverse of the JPEG quantizer stage. It accepts a stream of signed 8-bit quantized coefficients, one 8x8 block (64 beats) at a time, in the same raster index order the quantizer uses. Each coefficient is multiplied by the standard luminance quantization table entry for its index, and the result is emitted as a saturated signed 12-bit DCT coefficient. It sits in the decode path between the entropy decoder/de-zigzag and the IDCT, with valid/ready handshakes on both sides.

## Interface
Parameters:
- QW, 8: quantized input width (signed).
- DW, 12: output coefficient width (signed); the output saturates to this range.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat is valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_sop  input  1  beat is index 0 of a new block.
- in_data  input  QW  signed quantized coefficient.
- out_valid  output  1  output beat is valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DW  signed dequantized coefficient.
- out_addr  output  6  index (0..63) of out_data within the block.
- out_last  output  1  out_addr == 63.
- out_sat  output  1  out_data was clipped.
- err_align  output  1  sticky; set on an in_sop/index mismatch.

## Operation
- Accept occurs when in_valid && in_ready.
- Index counter idx (6 bit) assigns the index of each accepted beat:
  - If in_sop is set, the beat is index 0 and idx becomes 1.
  - Otherwise the beat takes idx, and idx increments, wrapping 63 -> 0.
- err_align is set when an accepted beat has:
  - in_sop=1 while idx != 0, or
  - in_sop=0 while idx == 0 and a previous block has completed.
  - The first beat after reset with in_sop=0 is allowed.
  - err_align is cleared only by rst.
- Stage 1 registers in_data, the index, and q_val from the table lookup.
- Stage 2 computes the product in_data * q_val at full width (QW+8 bits, signed; q_val treated as unsigned 8-bit). It then saturates to [-2^(DW-1), 2^(DW-1)-1] and registers out_data, out_addr, out_last and out_sat.
- The table is the standard JPEG luminance table, indexed 0..63 in raster order, identical to the one the quantizer uses. Index 0 = 16, 1 = 11, 37 = 109, 63 = 99.
- No rounding is performed. The result is the exact product, then saturated.

## Timing
- Two-stage pipeline; latency is 2 cycles from accept to out_valid when there is no backpressure.
- Throughput is 1 beat per cycle with out_ready held high.
- Stage 2 may load when !s2_valid || out_ready.
- Stage 1 may load when !s1_valid || stage 2 is loading.
- in_ready equals the stage 1 load condition. It is combinational from out_ready; there is no bubble on the release of a stall.
- While out_valid && !out_ready, out_data, out_addr, out_last and out_sat hold stable.
- Reset values: out_valid=0, out_data=0, out_addr=0, out_last=0, out_sat=0, err_align=0, idx=0, both stage valids 0.
  - in_ready is 1 during and after reset.
- rst asserted mid-block discards both stages and the partial block. The next accepted beat is index 0.
- Simultaneous load and drain in the same cycle in either stage is legal and must lose no data.

## Structure
- Shared package jpeg_pkg holds:
  - the 64-entry luminance table constant (8-bit entries);
  - the block size constant 64;
  - the width constants QW and DW.
  - The quantizer is refactored to use the same package.
- One sub-module: jpeg_qtable_rom, a combinational 6-bit address to 8-bit q_val lookup from jpeg_pkg, also instantiated by the quantizer.
- The pipeline, index counter and saturation logic live in jpeg_dequantizer.

## Test plan
- Reset then one full block with in_sop on beat 0, in_data=1 on every beat and out_ready=1:
  - Outputs equal the table values (16, 11, 10, …, 99).
  - out_addr runs 0..63, with out_last only on beat 63.
  - The first out_valid appears 2 cycles after the first accept.
- Saturation:
  - idx 37, in_data=20 -> out_data=2047, out_sat=1.
  - idx 0, in_data=-128 -> out_data=-2048, out_sat=0.
  - idx 1, in_data=-128 -> -1408, out_sat=0.
  - idx 0, in_data=5 -> 80.
- Backpressure: random out_ready (about 50%) over 4 blocks.
  - The output sequence equals the reference model with no drops or duplicates.
  - Outputs stay stable while stalled.
  - in_ready drops only when both stages are full and out_ready=0.
- Alignment:
  - in_sop on beat 10 of a block -> err_align=1 from the next cycle, and that beat is output with out_addr=0.
  - A subsequent clean block still produces correct data.
- Index wrap without in_sop on later blocks: after a block that started with in_sop, a second 64-beat block with in_sop=0 on its first beat wraps to addr 0 and sets err_align=1.
- Mid-block reset:
  - Assert rst after 20 accepts, with out_valid=1 and out_ready=0 -> out_valid=0 immediately.
  - After release, a new block with in_data=2 yields out_data=32 at addr 0.
